// File: rtl/norz_seq_pkg.sv
// Shared definitions for the machine-cycle sequencer.
// Contents:
//   cycle_kind_e   - current machine cycle kind (INT / M1 / MR / MW)
//   T1..T4         - 1-based T-state constants
//   XPT_W_DEF      - default width of the execution phase counter
//   strobes_t      - bus strobe bundle
//   decode_strobes - strobe pattern for a given cycle kind and T-state
package norz_seq_pkg;

    localparam int XPT_W_DEF = 5;

    typedef enum logic [1:0] {
        CK_INT = 2'd0,
        CK_M1  = 2'd1,
        CK_MR  = 2'd2,
        CK_MW  = 2'd3
    } cycle_kind_e;

    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;

    typedef struct packed {
        logic m1;
        logic mreq;
        logic rd;
        logic wr;
        logic rfsh;
    } strobes_t;

    // The wait substate keeps tstate at T2, so it decodes exactly like T2.
    function automatic strobes_t decode_strobes(cycle_kind_e kind, logic [2:0] t);
        strobes_t s;
        s = '0;
        case (kind)
            CK_M1: begin
                if (t <= T2) begin
                    s.m1   = 1'b1;
                    s.mreq = 1'b1;
                    s.rd   = 1'b1;
                end else begin
                    s.mreq = 1'b1;
                    s.rfsh = 1'b1;
                end
            end
            CK_MR: begin
                if (t <= T2) begin
                    s.mreq = 1'b1;
                    s.rd   = 1'b1;
                end
            end
            CK_MW: begin
                if (t <= T2) s.mreq = 1'b1;
                if (t == T2) s.wr   = 1'b1;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/xpt_counter.sv
// Saturating execution-phase counter with synchronous clear.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (xpt=0, not_xpt=all-ones)
//   advance  in   cycle boundary strobe; counter only moves when set
//   clear    in   on advance: load 0 instead of incrementing
//   xpt      out  W  phase count, saturates at 2**W-1
//   not_xpt  out  W  registered complement of xpt, updated on the same edge
module xpt_counter #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         advance,
    input  logic         clear,
    output logic [W-1:0] xpt,
    output logic [W-1:0] not_xpt
);

    logic [W-1:0] xpt_q;
    logic [W-1:0] nxpt_q;
    logic [W-1:0] xpt_nxt;

    always_comb begin
        xpt_nxt = xpt_q;
        if (clear)
            xpt_nxt = '0;
        else if (xpt_q != {W{1'b1}})
            xpt_nxt = xpt_q + 1'b1;
    end

    // Complement is its own register fed from the same next value so the
    // two outputs can never be skewed by a cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            xpt_q  <= '0;
            nxpt_q <= '1;
        end else if (advance) begin
            xpt_q  <= xpt_nxt;
            nxpt_q <= ~xpt_nxt;
        end
    end

    assign xpt     = xpt_q;
    assign not_xpt = nxpt_q;

endmodule

// File: rtl/xpt_cycle_sequencer.sv
// Machine-cycle sequencer for the op decoder tree. Sequences M1 fetch,
// memory read, memory write and internal cycles T-state by T-state, inserts
// wait states in T2 while memory is not ready, and owns the XPT phase counter.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   enable                 0 freezes every register
//   Reset_XPT              at cycle boundary: XPT <= 0
//   Set_CM1/Set_CMR/Set_CMW next-cycle kind request (priority M1 > MR > MW > INT)
//   mem_ready              memory handshake, sampled at end of T2 / wait
//   XPT, notXPT            phase counter and its registered complement
//   cycle_kind             0 INT, 1 M1, 2 MR, 3 MW
//   tstate                 current T-state, 1-based
//   cyc_last               final T-state of the current cycle
//   mreq, rd, wr, rfsh, m1 registered bus strobes, active-high
//   wait_st                inserted wait state
//   req_conflict           sticky: more than one kind request at a boundary
import norz_seq_pkg::*;

module xpt_cycle_sequencer #(
    parameter int XPT_W       = XPT_W_DEF,
    parameter int M1_TSTATES  = int'(T4),
    parameter int MEM_TSTATES = int'(T3)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             Reset_XPT,
    input  logic             Set_CM1,
    input  logic             Set_CMR,
    input  logic             Set_CMW,
    input  logic             mem_ready,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic [1:0]       cycle_kind,
    output logic [2:0]       tstate,
    output logic             cyc_last,
    output logic             mreq,
    output logic             rd,
    output logic             wr,
    output logic             rfsh,
    output logic             m1,
    output logic             wait_st,
    output logic             req_conflict
);

    cycle_kind_e kind_q, kind_d;
    logic [2:0]  t_q, t_d;
    logic        wait_q, wait_d;
    logic        conflict_q, conflict_d;
    strobes_t    stb_q, stb_d;
    logic [2:0]  last_t;
    logic        boundary;

    always_comb begin
        kind_d     = kind_q;
        t_d        = t_q;
        wait_d     = wait_q;
        conflict_d = conflict_q;
        boundary   = 1'b0;

        case (kind_q)
            CK_INT:  last_t = T1;
            CK_M1:   last_t = 3'(M1_TSTATES);
            default: last_t = 3'(MEM_TSTATES);
        endcase
        cyc_last = (t_q == last_t) && !wait_q;

        if (enable) begin
            if (cyc_last) begin
                boundary = 1'b1;
                t_d      = T1;
                wait_d   = 1'b0;
                if (Set_CM1)      kind_d = CK_M1;
                else if (Set_CMR) kind_d = CK_MR;
                else if (Set_CMW) kind_d = CK_MW;
                else              kind_d = CK_INT;
                if ($countones({Set_CM1, Set_CMR, Set_CMW}) > 1)
                    conflict_d = 1'b1;
            end else if (t_q == T2 && kind_q != CK_INT) begin
                // End of T2 or of a wait state: advance only once memory is ready.
                if (mem_ready) begin
                    t_d    = T3;
                    wait_d = 1'b0;
                end else begin
                    wait_d = 1'b1;
                end
            end else begin
                t_d = t_q + 3'd1;
            end
        end

        // Strobes are decoded from the next state and registered, so they
        // change exactly with the state and never glitch.
        stb_d = decode_strobes(kind_d, t_d);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            kind_q     <= CK_M1;
            t_q        <= T1;
            wait_q     <= 1'b0;
            conflict_q <= 1'b0;
            stb_q      <= decode_strobes(CK_M1, T1);
        end else begin
            kind_q     <= kind_d;
            t_q        <= t_d;
            wait_q     <= wait_d;
            conflict_q <= conflict_d;
            stb_q      <= stb_d;
        end
    end

    xpt_counter #(.W(XPT_W)) u_xpt (
        .clock   (clock),
        .reset   (reset),
        .advance (boundary),
        .clear   (Reset_XPT),
        .xpt     (XPT),
        .not_xpt (notXPT)
    );

    assign cycle_kind   = kind_q;
    assign tstate       = t_q;
    assign wait_st      = wait_q;
    assign req_conflict = conflict_q;
    assign m1           = stb_q.m1;
    assign mreq         = stb_q.mreq;
    assign rd           = stb_q.rd;
    assign wr           = stb_q.wr;
    assign rfsh         = stb_q.rfsh;

endmodule

// File: tb/tb_xpt_cycle_sequencer.sv
// Directed bench for xpt_cycle_sequencer. Each step drives inputs before a
// rising edge and queues the hand-computed state expected after that edge;
// a monitor pops and compares shortly after every rising edge.
module tb_xpt_cycle_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b1, enable = 1'b1, Reset_XPT = 1'b0;
    logic       Set_CM1 = 1'b0, Set_CMR = 1'b0, Set_CMW = 1'b0, mem_ready = 1'b1;
    logic [4:0] XPT, notXPT;
    logic [1:0] cycle_kind;
    logic [2:0] tstate;
    logic       cyc_last, mreq, rd, wr, rfsh, m1, wait_st, req_conflict;

    xpt_cycle_sequencer dut (
        .clock(clock), .reset(reset), .enable(enable), .Reset_XPT(Reset_XPT),
        .Set_CM1(Set_CM1), .Set_CMR(Set_CMR), .Set_CMW(Set_CMW), .mem_ready(mem_ready),
        .XPT(XPT), .notXPT(notXPT), .cycle_kind(cycle_kind), .tstate(tstate),
        .cyc_last(cyc_last), .mreq(mreq), .rd(rd), .wr(wr), .rfsh(rfsh), .m1(m1),
        .wait_st(wait_st), .req_conflict(req_conflict)
    );

    always #5 clock = ~clock;

    // input vector bits: {enable, reset, Reset_XPT, Set_CM1, Set_CMR, Set_CMW, mem_ready}
    localparam logic [6:0] EN  = 7'b1000000;
    localparam logic [6:0] RS  = 7'b0100000;
    localparam logic [6:0] RX  = 7'b0010000;
    localparam logic [6:0] C1  = 7'b0001000;
    localparam logic [6:0] CR  = 7'b0000100;
    localparam logic [6:0] CW  = 7'b0000010;
    localparam logic [6:0] RDY = 7'b0000001;
    localparam logic [6:0] RUN = EN | RDY;

    localparam logic [1:0] K_INT = 2'd0, K_M1 = 2'd1, K_MR = 2'd2, K_MW = 2'd3;
    // strobes as {m1, mreq, rd, wr, rfsh}
    localparam logic [4:0] S_0    = 5'b00000;
    localparam logic [4:0] S_M1RD = 5'b11100;
    localparam logic [4:0] S_RF   = 5'b01001;
    localparam logic [4:0] S_MR   = 5'b01100;
    localparam logic [4:0] S_MW1  = 5'b01000;
    localparam logic [4:0] S_MW2  = 5'b01010;

    typedef struct {
        logic [1:0] k;
        logic [2:0] t;
        logic [4:0] x;
        logic [4:0] s;
        logic       w;
        logic       l;
        logic       cf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (time %0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clock) begin
        exp_t       e;
        logic [4:0] nx;
        #1;
        if (sb.size() > 0) begin
            e  = sb.pop_front();
            nx = ~e.x;
            chk("cycle_kind",   int'(cycle_kind), int'(e.k));
            chk("tstate",       int'(tstate),     int'(e.t));
            chk("XPT",          int'(XPT),        int'(e.x));
            chk("notXPT",       int'(notXPT),     int'(nx));
            chk("strobes",      int'({m1, mreq, rd, wr, rfsh}), int'(e.s));
            chk("wait_st",      int'(wait_st),    int'(e.w));
            chk("cyc_last",     int'(cyc_last),   int'(e.l));
            chk("req_conflict", int'(req_conflict), int'(e.cf));
        end
    end

    task automatic step(input logic [6:0] in, input logic [1:0] k, input int t, input int x,
                        input logic [4:0] s, input logic w, input logic l, input logic cf);
        exp_t e;
        @(negedge clock);
        {enable, reset, Reset_XPT, Set_CM1, Set_CMR, Set_CMW, mem_ready} = in;
        e.k = k; e.t = t[2:0]; e.x = x[4:0]; e.s = s; e.w = w; e.l = l; e.cf = cf;
        sb.push_back(e);
        step_no++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        step(RUN | RS, K_M1, 1, 0, S_M1RD, 0, 0, 0);

        // back-to-back M1, Set_CM1 held (ignored outside cyc_last)
        for (int i = 0; i < 3; i++) begin
            step(RUN | C1, K_M1, 2, i,     S_M1RD, 0, 0, 0);
            step(RUN | C1, K_M1, 3, i,     S_RF,   0, 0, 0);
            step(RUN | C1, K_M1, 4, i,     S_RF,   0, 1, 0);
            step(RUN | C1, K_M1, 1, i + 1, S_M1RD, 0, 0, 0);
        end

        // M1 then MR with three wait states
        step(RUN,      K_M1, 2, 3, S_M1RD, 0, 0, 0);
        step(RUN,      K_M1, 3, 3, S_RF,   0, 0, 0);
        step(RUN,      K_M1, 4, 3, S_RF,   0, 1, 0);
        step(RUN | CR, K_MR, 1, 4, S_MR,   0, 0, 0);
        step(EN,       K_MR, 2, 4, S_MR,   0, 0, 0);
        step(EN,       K_MR, 2, 4, S_MR,   1, 0, 0);
        step(EN,       K_MR, 2, 4, S_MR,   1, 0, 0);
        step(EN,       K_MR, 2, 4, S_MR,   1, 0, 0);
        step(RUN,      K_MR, 3, 4, S_0,    0, 1, 0);

        // MW: wr only in T2, mreq T1-T2; then INT, then M1
        step(RUN | CW, K_MW,  1, 5, S_MW1,  0, 0, 0);
        step(RUN,      K_MW,  2, 5, S_MW2,  0, 0, 0);
        step(RUN,      K_MW,  3, 5, S_0,    0, 1, 0);
        step(RUN,      K_INT, 1, 6, S_0,    0, 1, 0);
        step(RUN | C1, K_M1,  1, 7, S_M1RD, 0, 0, 0);
        step(RUN,      K_M1,  2, 7, S_M1RD, 0, 0, 0);
        step(RUN,      K_M1,  3, 7, S_RF,   0, 0, 0);
        step(RUN,      K_M1,  4, 7, S_RF,   0, 1, 0);

        // Reset_XPT with Set_CM1 at XPT=7
        step(RUN | RX | C1, K_M1, 1, 0, S_M1RD, 0, 0, 0);
        step(RUN,      K_M1, 2, 0, S_M1RD, 0, 0, 0);
        step(RUN,      K_M1, 3, 0, S_RF,   0, 0, 0);
        step(RUN,      K_M1, 4, 0, S_RF,   0, 1, 0);

        // Reset_XPT alone -> INT at 0, then count up and saturate at 31
        step(RUN | RX, K_INT, 1, 0, S_0, 0, 1, 0);
        for (int i = 1; i <= 34; i++)
            step(RUN, K_INT, 1, (i > 31) ? 31 : i, S_0, 0, 1, 0);

        // MR+MW requested together: MR wins, conflict sticky
        step(RUN | CR | CW, K_MR, 1, 31, S_MR, 0, 0, 1);
        step(RUN,      K_MR, 2, 31, S_MR,  0, 0, 1);
        step(RUN,      K_MR, 3, 31, S_0,   0, 1, 1);
        step(RUN | CW, K_MW, 1, 31, S_MW1, 0, 0, 1);
        step(EN,       K_MW, 2, 31, S_MW2, 0, 0, 1);
        step(EN,       K_MW, 2, 31, S_MW2, 1, 0, 1);

        // reset while in WAIT of MW
        step(EN | RS,  K_M1, 1, 0, S_M1RD, 0, 0, 0);
        step(RUN,      K_M1, 2, 0, S_M1RD, 0, 0, 0);

        // enable low for 5 clocks mid-cycle: everything frozen
        for (int i = 0; i < 5; i++) begin
            logic [6:0] v;
            v = C1 | RX | CW;
            v[0] = i[0];
            step(v, K_M1, 2, 0, S_M1RD, 0, 0, 0);
        end
        step(RUN, K_M1,  3, 0, S_RF, 0, 0, 0);
        step(RUN, K_M1,  4, 0, S_RF, 0, 1, 0);
        step(RUN, K_INT, 1, 1, S_0,  0, 1, 0);

        repeat (3) @(posedge clock);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
